stepper_move_ctrl: RTL and testbench



---
 rtl/stepper_move_ctrl_pkg.sv | 31 +++
 rtl/stepper_phase_seq.sv | 46 ++++
 rtl/stepper_move_ctrl.sv | 147 ++++++++++++++
 tb/tb_stepper_move_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_move_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stepper_move_ctrl_pkg
// Shared definitions for the stepper move controller:
//   - coil phase pattern constants (full-step and half-step members)
//   - default step period constant (clocks per step minus one)
//   - move FSM state encoding
// Half-step sequencing is selected at build time with STEPPER_HALF_STEP_EN
// (used inside stepper_phase_seq).
// -----------------------------------------------------------------------------
package stepper_move_ctrl_pkg;

    // Coil patterns, named by their bit pattern.
    localparam logic [3:0] PH_1100 = 4'b1100;
    localparam logic [3:0] PH_0110 = 4'b0110;
    localparam logic [3:0] PH_0011 = 4'b0011;
    localparam logic [3:0] PH_1001 = 4'b1001;
    localparam logic [3:0] PH_1000 = 4'b1000;
    localparam logic [3:0] PH_0100 = 4'b0100;
    localparam logic [3:0] PH_0010 = 4'b0010;
    localparam logic [3:0] PH_0001 = 4'b0001;

    // Default step period for sequencers that do not program one.
    localparam int unsigned DEF_PERIOD = 49_999;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

endpackage

// File: rtl/stepper_phase_seq.sv
// -----------------------------------------------------------------------------
// stepper_phase_seq
// Combinational phase sequencer: given the current coil pattern and a
// direction, returns the next pattern and whether the current pattern is a
// member of the active sequence.
// Build option: STEPPER_HALF_STEP_EN selects the 8-phase half-step sequence;
// otherwise only the 4-phase full-step sequence exists.
// Ports:
//   i_phase  in  4  current coil pattern
//   i_dir    in  1  1 = forward, 0 = reverse
//   o_next   out 4  next pattern (i_phase when not a valid phase)
//   o_valid  out 1  i_phase belongs to the active sequence
// -----------------------------------------------------------------------------
module stepper_phase_seq
    import stepper_move_ctrl_pkg::*;
(
    input  logic [3:0] i_phase,
    input  logic       i_dir,
    output logic [3:0] o_next,
    output logic       o_valid
);

    always_comb begin
        o_next  = i_phase;
        o_valid = 1'b0;
        case (i_phase)
`ifdef STEPPER_HALF_STEP_EN
            PH_1000: begin o_valid = 1'b1; o_next = i_dir ? PH_1100 : PH_1001; end
            PH_1100: begin o_valid = 1'b1; o_next = i_dir ? PH_0100 : PH_1000; end
            PH_0100: begin o_valid = 1'b1; o_next = i_dir ? PH_0110 : PH_1100; end
            PH_0110: begin o_valid = 1'b1; o_next = i_dir ? PH_0010 : PH_0100; end
            PH_0010: begin o_valid = 1'b1; o_next = i_dir ? PH_0011 : PH_0110; end
            PH_0011: begin o_valid = 1'b1; o_next = i_dir ? PH_0001 : PH_0010; end
            PH_0001: begin o_valid = 1'b1; o_next = i_dir ? PH_1001 : PH_0011; end
            PH_1001: begin o_valid = 1'b1; o_next = i_dir ? PH_1000 : PH_0001; end
`else
            PH_1100: begin o_valid = 1'b1; o_next = i_dir ? PH_0110 : PH_1001; end
            PH_0110: begin o_valid = 1'b1; o_next = i_dir ? PH_0011 : PH_1100; end
            PH_0011: begin o_valid = 1'b1; o_next = i_dir ? PH_1001 : PH_0110; end
            PH_1001: begin o_valid = 1'b1; o_next = i_dir ? PH_1100 : PH_0011; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/stepper_move_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_move_ctrl
// Per-axis stepper move controller: on a held go request it steps the coil
// pattern a latched number of times in a latched direction, one step every
// (period+1) clocks, stopping early on the end-stop or on go being dropped.
// Build option: STEPPER_HALF_STEP_EN (8-phase half-step sequence).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_go           level move request / acknowledge
//   i_dir          1 = forward, 0 = reverse (latched at move start)
//   i_steps        steps to take (latched at move start)
//   i_period       clocks per step minus one (latched; 0 treated as 1)
//   i_old_state    coil pattern followed while idle
//   i_boundary     end-stop for the current direction
//   o_state        coil drive pattern
//   o_busy         move in progress
//   o_done         move finished, waiting for go to drop
//   o_steps_done   steps taken in the current / last move (saturating)
// -----------------------------------------------------------------------------
module stepper_move_ctrl
    import stepper_move_ctrl_pkg::*;
#(
    parameter int         STEP_W     = 12,
    parameter int         PER_W      = 24,
    parameter logic [3:0] INIT_PHASE = 4'b1100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_go,
    input  logic              i_dir,
    input  logic [STEP_W-1:0] i_steps,
    input  logic [PER_W-1:0]  i_period,
    input  logic [3:0]        i_old_state,
    input  logic              i_boundary,
    output logic [3:0]        o_state,
    output logic              o_busy,
    output logic              o_done,
    output logic [STEP_W-1:0] o_steps_done
);

    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    fsm_t              r_fsm;
    fsm_t              w_fsm_next;
    logic [3:0]        r_state;
    logic [PER_W-1:0]  r_cnt;
    logic [STEP_W-1:0] r_steps_done;
    logic [STEP_W-1:0] r_steps;
    logic              r_dir;
    logic [PER_W-1:0]  r_period;

    logic              w_stay_run;
    logic              w_tick;
    logic [3:0]        w_seq_in;
    logic [3:0]        w_seq_next;
    logic              w_seq_valid;
    logic [3:0]        w_load_phase;
    logic [3:0]        w_step_phase;

    // One sequencer serves both paths: while a move continues it steps the
    // live pattern, otherwise it validates the idle pattern being loaded.
    assign w_stay_run = (r_fsm == S_RUN) && (w_fsm_next == S_RUN);
    assign w_seq_in   = w_stay_run ? r_state : i_old_state;
    assign w_tick     = w_stay_run && (r_cnt == r_period);

    assign w_load_phase = w_seq_valid ? i_old_state : INIT_PHASE;
    assign w_step_phase = w_seq_valid ? w_seq_next  : INIT_PHASE;

    stepper_phase_seq u_phase_seq (
        .i_phase (w_seq_in),
        .i_dir   (r_dir),
        .o_next  (w_seq_next),
        .o_valid (w_seq_valid)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // FSM next state; boundary outranks completion, and completion is
    // checked before any further tick so the final step is never exceeded.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_IDLE: begin
                if (i_go) begin
                    if (i_boundary || (i_steps == '0)) w_fsm_next = S_DONE;
                    else                               w_fsm_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!i_go)                              w_fsm_next = S_IDLE;
                else if (i_boundary)                    w_fsm_next = S_DONE;
                else if (r_steps_done == r_steps)       w_fsm_next = S_DONE;
            end
            S_DONE: begin
                if (!i_go) w_fsm_next = S_IDLE;
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy = (r_fsm == S_RUN);
        o_done = (r_fsm == S_DONE);
    end

    // Coil pattern, period counter and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INIT_PHASE;
            r_cnt        <= '0;
            r_steps_done <= '0;
        end else if ((w_fsm_next == S_IDLE) || (r_fsm == S_IDLE)) begin
            r_state      <= w_load_phase;
            r_cnt        <= '0;
            r_steps_done <= '0;
        end else if (w_tick) begin
            r_state      <= w_step_phase;
            r_cnt        <= '0;
            r_steps_done <= sat_inc(r_steps_done);
        end else if (w_stay_run) begin
            r_cnt        <= r_cnt + 1'b1;
        end
    end

    // Move parameters, captured only on IDLE -> RUN
    always_ff @(posedge clk) begin
        if ((r_fsm == S_IDLE) && (w_fsm_next == S_RUN)) begin
            r_steps  <= i_steps;
            r_dir    <= i_dir;
            r_period <= (i_period == '0) ? {{(PER_W-1){1'b0}}, 1'b1} : i_period;
        end
    end

    assign o_state      = r_state;
    assign o_steps_done = r_steps_done;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
module tb_stepper_move_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        dir = 1'b1;
    logic [11:0] steps = '0;
    logic [23:0] period = '0;
    logic [3:0]  old_state = 4'b1100;
    logic        boundary = 1'b0;
    logic [3:0]  o_state;
    logic        o_busy;
    logic        o_done;
    logic [11:0] o_steps_done;

    stepper_move_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_go         (go),
        .i_dir        (dir),
        .i_steps      (steps),
        .i_period     (period),
        .i_old_state  (old_state),
        .i_boundary   (boundary),
        .o_state      (o_state),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_steps_done (o_steps_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic        busy;
        logic        done;
        logic [11:0] sd;
        int          dt;
    } ev_t;

    ev_t         exp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          mark_cyc = 0;
    logic        mon_en = 1'b0;
    logic [17:0] prev_snap = '0;
    logic [17:0] snap;
    int          base;
    ev_t         e;

`ifdef STEPPER_HALF_STEP_EN
    localparam int NPH = 8;
    logic [3:0] seq_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
    localparam int NPH = 4;
    logic [3:0] seq_tab [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif

    function automatic logic [3:0] nxt(input logic [3:0] p, input logic d);
        logic [3:0] r;
        r = p;
        for (int i = 0; i < NPH; i++)
            if (seq_tab[i] == p) r = d ? seq_tab[(i + 1) % NPH] : seq_tab[(i + NPH - 1) % NPH];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output tuple is one presented result.
    always @(negedge clk) begin
        if (mon_en) begin
            snap = {o_state, o_busy, o_done, o_steps_done};
            if (snap !== prev_snap) begin
                base = (mark_cyc > last_cyc) ? mark_cyc : last_cyc;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got state=%b busy=%b done=%b steps_done=%0d, required no change",
                             o_state, o_busy, o_done, o_steps_done);
                end else begin
                    e = exp_q.pop_front();
                    if (snap !== {e.st, e.busy, e.done, e.sd} || (cyc - base) != e.dt) begin
                        n_fail++;
                        $display("FAIL event: got state=%b busy=%b done=%b steps_done=%0d after %0d clk, required state=%b busy=%b done=%b steps_done=%0d after %0d clk",
                                 o_state, o_busy, o_done, o_steps_done, cyc - base,
                                 e.st, e.busy, e.done, e.sd, e.dt);
                    end
                end
                prev_snap = snap;
                last_cyc  = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic mark();
        mark_cyc = cyc;
    endtask

    task automatic push(input logic [3:0] st, input logic b, input logic d,
                        input logic [11:0] sd, input int dt);
        ev_t x;
        x.st = st; x.busy = b; x.done = d; x.sd = sd; x.dt = dt;
        exp_q.push_back(x);
    endtask

    task automatic push_move(input logic [3:0] st, input logic d, input int n, input int per);
        int         pe;
        logic [3:0] p;
        pe = (per == 0) ? 1 : per;
        p  = st;
        push(st, 1'b1, 1'b0, 12'd0, 1);
        for (int i = 1; i <= n; i++) begin
            p = nxt(p, d);
            push(p, 1'b1, 1'b0, 12'(i), pe + 1);
        end
        push(p, 1'b0, 1'b1, 12'(n), 1);
    endtask

    task automatic chk(input string name, input int got, input int req);
        n_vec++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!o_done && k < budget) begin
            tick(1);
            k++;
        end
        if (!o_done) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: got done=0 after %0d clk, required done=1", budget);
        end
    endtask

    // Drop go and expect the idle pattern with cleared count one clock later.
    task automatic release_go(input logic [3:0] idle_st);
        push(idle_st, 1'b0, 1'b0, 12'd0, 1);
        go = 1'b0;
        boundary = 1'b0;
        mark();
        tick(3);
    endtask

    task automatic start_move(input logic d, input int n, input int per);
        dir    = d;
        steps  = 12'(n);
        period = 24'(per);
        go     = 1'b1;
        mark();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required summary earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        tick(3);
        chk("reset_state", o_state, 4'b1100);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_steps_done", o_steps_done, 0);
        prev_snap = {o_state, o_busy, o_done, o_steps_done};
        mon_en = 1'b1;
        rst = 1'b0;
        tick(2);

        // Forward 5 steps, period 3; mid-move input changes must be ignored
        push_move(4'b1100, 1'b1, 5, 3);
        start_move(1'b1, 5, 3);
        tick(1);
        steps = 12'd1; dir = 1'b0; period = 24'd0;
        wait_done(100);
        release_go(4'b1100);

        // Reverse 3 steps, period 1
        push_move(4'b1100, 1'b0, 3, 1);
        start_move(1'b0, 3, 1);
        wait_done(100);
        release_go(4'b1100);

        // Boundary coincident with the 3rd step tick of a 10-step move
        push(4'b1100, 1'b1, 1'b0, 12'd0, 1);
        push(nxt(4'b1100, 1'b1), 1'b1, 1'b0, 12'd1, 3);
        push(nxt(nxt(4'b1100, 1'b1), 1'b1), 1'b1, 1'b0, 12'd2, 3);
        push(nxt(nxt(4'b1100, 1'b1), 1'b1), 1'b0, 1'b1, 12'd2, 3);
        start_move(1'b1, 10, 2);
        tick(9);
        boundary = 1'b1;
        wait_done(20);
        release_go(4'b1100);

        // go with boundary already set in IDLE
        push(4'b1100, 1'b0, 1'b1, 12'd0, 1);
        boundary = 1'b1;
        start_move(1'b1, 4, 1);
        wait_done(10);
        release_go(4'b1100);

        // steps = 0
        push(4'b1100, 1'b0, 1'b1, 12'd0, 1);
        start_move(1'b1, 0, 1);
        wait_done(10);
        release_go(4'b1100);

        // period = 0 behaves as period = 1
        push_move(4'b1100, 1'b1, 2, 0);
        start_move(1'b1, 2, 0);
        wait_done(50);
        release_go(4'b1100);

        // Abort after 2 of 8 steps, idle pattern 0011
        push(4'b0011, 1'b0, 1'b0, 12'd0, 1);
        old_state = 4'b0011;
        mark();
        tick(2);
        push(4'b0011, 1'b1, 1'b0, 12'd0, 1);
        push(nxt(4'b0011, 1'b1), 1'b1, 1'b0, 12'd1, 2);
        push(nxt(nxt(4'b0011, 1'b1), 1'b1), 1'b1, 1'b0, 12'd2, 2);
        start_move(1'b1, 8, 1);
        tick(5);
        push(4'b0011, 1'b0, 1'b0, 12'd0, 1);
        go = 1'b0;
        tick(2);
        push(4'b1100, 1'b0, 1'b0, 12'd0, 1);
        old_state = 4'b1100;
        mark();
        tick(2);

        // Reset mid-move; idle pattern changed during RUN must not leak in
        push(4'b1100, 1'b1, 1'b0, 12'd0, 1);
        push(nxt(4'b1100, 1'b1), 1'b1, 1'b0, 12'd1, 2);
        start_move(1'b1, 8, 1);
        tick(1);
        old_state = 4'b1001;
        tick(3);
        push(4'b1100, 1'b0, 1'b0, 12'd0, 2);
        rst = 1'b1;
        go = 1'b0;
        tick(1);
        push(4'b1001, 1'b0, 1'b0, 12'd0, 1);
        rst = 1'b0;
        tick(2);
        push(4'b1100, 1'b0, 1'b0, 12'd0, 1);
        old_state = 4'b1100;
        mark();
        tick(2);

        // Invalid idle pattern loads the initial phase
        push(4'b0011, 1'b0, 1'b0, 12'd0, 1);
        old_state = 4'b0011;
        mark();
        tick(2);
        push(4'b1100, 1'b0, 1'b0, 12'd0, 1);
        old_state = 4'b1010;
        mark();
        tick(2);
        old_state = 4'b1100;
        tick(2);

`ifdef STEPPER_HALF_STEP_EN
        // Half-step: 8 forward steps from 1000 wrap back to 1000
        push(4'b1000, 1'b0, 1'b0, 12'd0, 1);
        old_state = 4'b1000;
        mark();
        tick(2);
        push_move(4'b1000, 1'b1, 8, 1);
        start_move(1'b1, 8, 1);
        wait_done(100);
        old_state = 4'b1100;
        release_go(4'b1100);
`endif

        tick(5);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL leftover_events: got %0d events still pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
